// File: rtl/disp_pkg.sv
// Shared widths, digit count and small helpers for the 7-segment scan path.
package disp_pkg;

   localparam int DIGIT_W    = 4;
   localparam int SEL_W      = 3;
   localparam int NUM_DIGITS = 6;

   typedef logic [DIGIT_W-1:0]    digit_t;
   typedef logic [SEL_W-1:0]      sel_t;
   typedef logic [NUM_DIGITS-1:0] anode_t;

   localparam sel_t LAST_SEL = 3'd5;

   function automatic anode_t anode_onehot(input sel_t sel);
      return anode_t'(1) << sel;
   endfunction

endpackage

// File: rtl/disp_scanner_if.sv
// Capture inputs from the BCD latch stage and scan outputs toward the segment decoder.
interface disp_scanner_if;
   import disp_pkg::*;

   logic   scan_en;
   logic   latch;
   digit_t Q5, Q4, Q3, Q2, Q1, Q0;
   logic   counter_out;

   digit_t snap_q5, snap_q4, snap_q3, snap_q2, snap_q1, snap_q0;
   logic   snap_ovf;
   sel_t   disp_select;
   digit_t disp_data;
   anode_t digit_en;

   modport master (
      output scan_en, latch, Q5, Q4, Q3, Q2, Q1, Q0, counter_out,
      input  snap_q5, snap_q4, snap_q3, snap_q2, snap_q1, snap_q0, snap_ovf,
      input  disp_select, disp_data, digit_en
   );

   modport slave (
      input  scan_en, latch, Q5, Q4, Q3, Q2, Q1, Q0, counter_out,
      output snap_q5, snap_q4, snap_q3, snap_q2, snap_q1, snap_q0, snap_ovf,
      output disp_select, disp_data, digit_en
   );

endinterface

// File: rtl/disp_scanner_prescaler.sv
// Scan-rate prescaler: counts 0..DIV-1 while enabled, ticks on the last count.
module scan_prescaler #(
   parameter int DIV = 10,
   parameter int CW  = $clog2(DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   output logic          tick_o,
   output logic [CW-1:0] count_nxt_o
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_q, count_d;

   assign tick_o = en_i && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = tick_o ? '0 : count_q + CW'(1);
      end
   end

   // exported as the post-edge value so registered anode logic lines up with the count
   assign count_nxt_o = count_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/disp_scanner.sv
// Six-digit display scanner: shadow-latches the BCD result and time-multiplexes it.
// Optional DISP_GHOST_BLANK_EN blanks anodes for the first GHOST_CYCLES clocks of each digit.
module disp_scanner
   import disp_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int SCAN_HZ      = 1_000,
   parameter int GHOST_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   disp_scanner_if.slave  bus
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = $clog2(DIV);

   logic          tick;
   logic [CW-1:0] count_nxt;
   logic          blank;

   sel_t   index_q, index_d;
   sel_t   sel_q;
   digit_t data_q, data_d;
   anode_t en_q, en_d;
   digit_t snap_q [NUM_DIGITS];
   logic   snap_ovf_q;

   scan_prescaler #(.DIV(DIV), .CW(CW)) u_prescaler (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (bus.scan_en),
      .tick_o      (tick),
      .count_nxt_o (count_nxt)
   );

`ifdef DISP_GHOST_BLANK_EN
   assign blank = (count_nxt < CW'(GHOST_CYCLES));
`else
   logic unused_ghost;
   assign blank        = 1'b0;
   assign unused_ghost = (^count_nxt) ^ (GHOST_CYCLES > 0);
`endif

   always_comb begin
      index_d = index_q;
      if (tick) begin
         index_d = (index_q == LAST_SEL) ? '0 : index_q + sel_t'(1);
      end
   end

   // data uses the pre-edge snapshot, so a latch shows up one clock later
   always_comb begin
      data_d = '0;
      case (index_d)
         3'd0:    data_d = snap_q[0];
         3'd1:    data_d = snap_q[1];
         3'd2:    data_d = snap_q[2];
         3'd3:    data_d = snap_q[3];
         3'd4:    data_d = snap_q[4];
         3'd5:    data_d = snap_q[5];
         default: data_d = '0;
      endcase
   end

   always_comb begin
      en_d = '0;
      if (bus.scan_en && !blank) begin
         en_d = anode_onehot(index_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_q    <= '0;
         sel_q      <= '0;
         data_q     <= '0;
         en_q       <= '0;
         snap_ovf_q <= 1'b0;
         for (int k = 0; k < NUM_DIGITS; k++) snap_q[k] <= '0;
      end else begin
         index_q <= index_d;
         sel_q   <= index_d;
         data_q  <= data_d;
         en_q    <= en_d;
         if (bus.latch) begin
            snap_q[0]  <= bus.Q5;
            snap_q[1]  <= bus.Q4;
            snap_q[2]  <= bus.Q3;
            snap_q[3]  <= bus.Q2;
            snap_q[4]  <= bus.Q1;
            snap_q[5]  <= bus.Q0;
            snap_ovf_q <= bus.counter_out;
         end
      end
   end

   assign bus.disp_select = sel_q;
   assign bus.disp_data   = data_q;
   assign bus.digit_en    = en_q;
   assign bus.snap_q5     = snap_q[0];
   assign bus.snap_q4     = snap_q[1];
   assign bus.snap_q3     = snap_q[2];
   assign bus.snap_q2     = snap_q[3];
   assign bus.snap_q1     = snap_q[4];
   assign bus.snap_q0     = snap_q[5];
   assign bus.snap_ovf    = snap_ovf_q;

endmodule

// File: tb/tb_disp_scanner.sv
// Bench for disp_scanner at DIV=10 against a cycle-level behavioural model.
module tb_disp_scanner;

   localparam int DIV = 10;
`ifdef DISP_GHOST_BLANK_EN
   localparam int G = 3;
`else
   localparam int G = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   disp_scanner_if bus();

   disp_scanner #(.CLK_HZ(60), .SCAN_HZ(6), .GHOST_CYCLES(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // model: position k shows digit Q(5-k)
   int m_cnt, m_idx, m_ovf;
   int m_snap [6];
   int e_sel, e_data, e_en;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_q(input int a5, a4, a3, a2, a1, a0);
      bus.Q5 = 4'(a5); bus.Q4 = 4'(a4); bus.Q3 = 4'(a3);
      bus.Q2 = 4'(a2); bus.Q1 = 4'(a1); bus.Q0 = 4'(a0);
   endtask

   task automatic model_reset();
      m_cnt = 0; m_idx = 0; m_ovf = 0;
      for (int k = 0; k < 6; k++) m_snap[k] = 0;
      e_sel = 0; e_data = 0; e_en = 0;
   endtask

   function automatic logic [23:0] model_snaps();
      return {4'(m_snap[0]), 4'(m_snap[1]), 4'(m_snap[2]),
              4'(m_snap[3]), 4'(m_snap[4]), 4'(m_snap[5])};
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, "_sel"},  32'(bus.disp_select), 32'(e_sel));
      chk({tag, "_data"}, 32'(bus.disp_data),   32'(e_data));
      chk({tag, "_en"},   32'(bus.digit_en),    32'(e_en));
      chk({tag, "_snap"}, 32'({bus.snap_q5, bus.snap_q4, bus.snap_q3,
                                bus.snap_q2, bus.snap_q1, bus.snap_q0}), 32'(model_snaps()));
      chk({tag, "_ovf"},  32'(bus.snap_ovf),    32'(m_ovf));
   endtask

   task automatic step(input string tag);
      int old [6];
      @(posedge clk);
      old = m_snap;
      if (bus.scan_en) begin
         if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 6;
         end else begin
            m_cnt++;
         end
      end
      if (bus.latch) begin
         m_snap[0] = int'(bus.Q5); m_snap[1] = int'(bus.Q4); m_snap[2] = int'(bus.Q3);
         m_snap[3] = int'(bus.Q2); m_snap[4] = int'(bus.Q1); m_snap[5] = int'(bus.Q0);
         m_ovf = int'(bus.counter_out);
      end
      e_sel  = m_idx;
      e_data = old[m_idx];
      e_en   = (bus.scan_en && m_cnt >= G) ? (1 << m_idx) : 0;
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int n, frozen;
      bit found;

      bus.scan_en = 1'b0;
      bus.latch = 1'b0;
      bus.counter_out = 1'b0;
      set_q(0, 0, 0, 0, 0, 0);
      model_reset();
      #23;
      check_outputs("reset");

      // 1: latch 1..6 and scan a full cycle
      @(negedge clk);
      rst_n = 1'b1;
      bus.scan_en = 1'b1;
      set_q(1, 2, 3, 4, 5, 6);
      bus.latch = 1'b1;
      step("t1");
      bus.latch = 1'b0;
      step("t1");
      chk("t1_first_data", 32'(bus.disp_data), 32'd1);
      chk("t1_first_en", 32'(bus.digit_en), 32'h01);
      for (int k = 1; k < 6; k++) begin
         repeat (10) step("t1");
         chk("t1_sel_k", 32'(bus.disp_select), 32'(k));
         chk("t1_data_k", 32'(bus.disp_data), 32'(k + 1));
         chk("t1_en_k", 32'(bus.digit_en), 32'(1 << k));
      end
      repeat (10) step("t1");
      chk("t1_wrap", 32'(bus.disp_select), 32'd0);

      // 2: inputs change without latch
      set_q(9, 9, 9, 9, 9, 9);
      bus.counter_out = 1'b1;
      repeat (12) step("t2");
      chk("t2_snap_hold", 32'({bus.snap_q5, bus.snap_q4, bus.snap_q3,
                               bus.snap_q2, bus.snap_q1, bus.snap_q0}), 32'h123456);
      chk("t2_ovf_hold", 32'(bus.snap_ovf), 32'd0);

      // 3: latch coincides with the 0->1 step
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_idx == 0 && m_cnt == DIV - 1) found = 1'b1;
         else step("t3");
      end
      chk("t3_found", 32'(found), 32'd1);
      set_q(9, 7, 9, 9, 9, 9);
      bus.latch = 1'b1;
      step("t3");
      bus.latch = 1'b0;
      chk("t3_sel", 32'(bus.disp_select), 32'd1);
      chk("t3_old_data", 32'(bus.disp_data), 32'd2);
      step("t3");
      chk("t3_new_data", 32'(bus.disp_data), 32'd7);

      // 4: pause mid digit 3
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_idx == 3 && m_cnt == 5) found = 1'b1;
         else step("t4");
      end
      chk("t4_found", 32'(found), 32'd1);
      frozen = m_cnt;
      bus.scan_en = 1'b0;
      step("t4");
      chk("t4_en_off", 32'(bus.digit_en), 32'd0);
      repeat (24) step("t4");
      chk("t4_sel_hold", 32'(bus.disp_select), 32'd3);
      bus.scan_en = 1'b1;
      n = 0;
      while (bus.disp_select != 3'd4 && n < 50) begin
         step("t4");
         n++;
      end
      chk("t4_resume_len", 32'(n), 32'(DIV - frozen));

      // 6: anode enable across one digit period
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         step("t6");
         if (m_cnt == 0) found = 1'b1;
      end
      chk("t6_found", 32'(found), 32'd1);
      for (int c = 0; c < DIV; c++) begin
         chk("t6_ghost", 32'(bus.digit_en), (c < G) ? 32'd0 : 32'(1 << m_idx));
         step("t6");
      end

      // 5: async reset at index 4
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_idx == 4) found = 1'b1;
         else step("t5");
      end
      chk("t5_found", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("t5_async");
      @(negedge clk);
      rst_n = 1'b1;
      step("t5");
      chk("t5_restart", 32'(bus.disp_select), 32'd0);
      repeat (15) step("t5");

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         bus.scan_en = ($urandom % 10) != 0;
         bus.latch = ($urandom % 6) == 0;
         bus.counter_out = 1'($urandom % 2);
         set_q($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
               $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
